dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, address width of the data-memory port.
REQ-002 Parameter DATA_W, default 32, data width of the data-memory port.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port req0, req1  in  1 each  access request from requester 0 or 1; held high until the matching gnt pulse.
REQ-006 Port we0, we1  in  1 each  1 = write, 0 = read; stable while reqN is high.
REQ-007 Port addr0, addr1  in  ADDR_W each  word address; stable while reqN is high.
REQ-008 Port wdata0, wdata1  in  DATA_W each  write data; stable while reqN is high.
REQ-009 Port gnt0, gnt1  out  1 each  one-cycle pulse; the request is accepted and issued to memory in this cycle.
REQ-010 Port rvalid0, rvalid1  out  1 each  one-cycle pulse; rdataN holds read data.
REQ-011 Port rdata0, rdata1  out  DATA_W each  last read data for that port; held until that port's next read completes.
REQ-012 Port we_DM  out  1  memory write enable.
REQ-013 Port addDM  out  ADDR_W  memory address.
REQ-014 Port dataDM  out  DATA_W  memory write data.
REQ-015 Port outDM  in  DATA_W  memory read data; valid one clock after addDM is sampled.
REQ-016 Port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and RWAIT, with all outputs registered.
REQ-018 IDLE: on any reqN, select the winner, latch its we, addr and wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE (one cycle): drive addDM and dataDM from the latch, set we_DM to the latched we, and pulse gntN for the winner only.
REQ-020 ISSUE exit: a write goes to IDLE; a read goes to RWAIT.
REQ-021 RWAIT (one cycle): capture outDM into rdataN of the winner, pulse rvalidN in the following cycle, and go to IDLE.
REQ-022 Latency: req sampled in cycle T gives gnt at T+1; a read gives rvalid at T+3.
REQ-023 Throughput: a write SHALL take 2 cycles per access; a read SHALL take 3 cycles.
REQ-024 Outside ISSUE, we_DM SHALL be 0, and addDM/dataDM SHALL hold their last driven values.
REQ-025 Round-robin arbitration:
  - the last-served pointer updates on every gnt;
  - if both reqs are high in IDLE, the port not last served wins;
  - if only one req is high, that port wins regardless of the pointer.
REQ-026 A req that drops before its gnt SHALL be ignored, with no memory access.
REQ-027 After its gnt, a requester SHALL drop req or present a new request; a req still high in IDLE is treated as a new request.
REQ-028 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together.
REQ-029 Addresses SHALL pass through unmodified, with no wrap logic; the address range is ADDR_W bits.

Reset
REQ-030 While rst_n is low, all outputs SHALL be 0: gnt, rvalid, rdata, we_DM, addDM, dataDM and busy.
REQ-031 Reset SHALL put the FSM in IDLE with the round-robin pointer set to port 1, so port 0 wins the first conflict.
REQ-032 Reset mid-operation SHALL abort the access immediately: we_DM drops asynchronously, and no rvalid is produced for an aborted read.
REQ-033 The first request SHALL be sampled on the first rising edge after rst_n deasserts.

Configuration
REQ-034 With the macro DM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win a conflict and the round-robin pointer SHALL not exist.
REQ-035 Without DM_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin as in REQ-025.

Verification
REQ-036 Port-0 write: req0, we0=1, addr0=0x001, wdata0=0x1DFE -> gnt0 one cycle later, with we_DM=1, addDM=0x001, dataDM=0x1DFE for exactly one cycle.
REQ-037 Read-back: port-1 read of 0x001 after REQ-036 -> rvalid1 at T+3 with rdata1=0x1DFE; rdata0 is unchanged.
REQ-038 Conflict: both ports write simultaneously, port 0 to 0x002/0x1EFE and port 1 to 0x003/0x1001, held for 4 accesses -> default build grants 0,1,0,1; DM_ARB_FIXED_PRIO_EN build grants 0,0,0,0 while req1 waits.
REQ-039 Reset mid-read: rst_n low during RWAIT -> we_DM=0, no rvalid, busy=0; the next read of 0x002 returns 0x1EFE.
REQ-040 Withdrawn request: req1 pulsed for one cycle while a port-0 access is busy -> no gnt1 and no memory access for port 1.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two requesters sharing one synchronous data-memory port, round-robin arbitrated.
// Build option: define DM_ARB_FIXED_PRIO_EN to make port 0 always win a conflict.
`timescale 1ns/1ps
module dm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              we_DM,
    output logic [ADDR_W-1:0] addDM,
    output logic [DATA_W-1:0] dataDM,
    input  logic [DATA_W-1:0] outDM,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

    state_t            r_state;
    logic              r_winner;
    logic              r_we;
    logic              r_gnt0, r_gnt1;
    logic              r_rvalid0, r_rvalid1;
    logic              r_we_dm;
    logic              r_busy;
    logic [ADDR_W-1:0] r_add_dm;
    logic [DATA_W-1:0] r_data_dm;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic              w_any_req;
    logic              w_pick1;

    assign w_any_req = req0 | req1;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    // r_last is the port served most recently; on a conflict the other one wins.
    logic r_last;

    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any_req) begin
            r_last <= w_pick1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_winner  <= 1'b0;
            r_we      <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_we_dm   <= 1'b0;
            r_busy    <= 1'b0;
            r_add_dm  <= '0;
            r_data_dm <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the state that owns them raises them.
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_we_dm   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ISSUE;
                        r_busy    <= 1'b1;
                        r_winner  <= w_pick1;
                        r_we      <= w_pick1 ? we1 : we0;
                        r_we_dm   <= w_pick1 ? we1 : we0;
                        r_add_dm  <= w_pick1 ? addr1 : addr0;
                        r_data_dm <= w_pick1 ? wdata1 : wdata0;
                        r_gnt0    <= ~w_pick1;
                        r_gnt1    <= w_pick1;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    // Memory answers one clock after it sampled the address in ISSUE.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (r_winner) begin
                        r_rdata1  <= outDM;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= outDM;
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign we_DM   = r_we_dm;
    assign addDM   = r_add_dm;
    assign dataDM  = r_data_dm;
    assign busy    = r_busy;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scoreboard bench for dm_arbiter with a synchronous RAM model.
// Expected grant order follows DM_ARB_FIXED_PRIO_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_dm_arbiter;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } gnt_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        we_DM;
    logic [11:0] addDM;
    logic [31:0] dataDM;
    logic [31:0] outDM;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_gnt_cyc = 0;
    int gnt_cnt0 = 0;
    int gnt_cnt1 = 0;

    gnt_t exp_gnt_q[$];
    rd_t  exp_rd_q[$];
    gnt_t mon_g;
    rd_t  mon_r;
    logic [31:0] exp_rdata [2];
    logic [31:0] ref_mem [4096] = '{default: 32'h0};
    logic [31:0] ram     [4096] = '{default: 32'h0};

    dm_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .we_DM(we_DM), .addDM(addDM), .dataDM(dataDM), .outDM(outDM),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_DM) ram[addDM] <= dataDM;
        outDM <= ram[addDM];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every grant and every read completion is matched in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rdata[0] = 32'h0;
            exp_rdata[1] = 32'h0;
        end
        if (gnt0 || gnt1) begin
            check("gnt_mutex", 64'(gnt0 & gnt1), 64'd0);
            check("gnt_expected", 64'(exp_gnt_q.size() != 0), 64'd1);
            if (exp_gnt_q.size() != 0) begin
                mon_g = exp_gnt_q.pop_front();
                check("gnt_port", 64'(gnt1), 64'(mon_g.port));
                check("we_DM_issue", 64'(we_DM), 64'(mon_g.we));
                check("addDM_issue", 64'(addDM), 64'(mon_g.addr));
                if (mon_g.we) check("dataDM_issue", 64'(dataDM), 64'(mon_g.data));
                else rd_gnt_cyc = cyc;
            end
            if (gnt1) gnt_cnt1++;
            else gnt_cnt0++;
        end
        if (rvalid0 || rvalid1) begin
            check("rvalid_mutex", 64'(rvalid0 & rvalid1), 64'd0);
            check("rvalid_expected", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0) begin
                mon_r = exp_rd_q.pop_front();
                check("rvalid_port", 64'(rvalid1), 64'(mon_r.port));
                check("rdata", 64'(rvalid1 ? rdata1 : rdata0), 64'(mon_r.data));
                check("read_latency", 64'(cyc - rd_gnt_cyc), 64'd2);
                exp_rdata[mon_r.port] = mon_r.data;
                if (mon_r.port) check("rdata0_hold", 64'(rdata0), 64'(exp_rdata[0]));
                else            check("rdata1_hold", 64'(rdata1), 64'(exp_rdata[1]));
            end
        end
    end

    task automatic expect_access(input logic p, input logic w, input logic [11:0] a,
                                 input logic [31:0] d, input bit aborted);
        gnt_t g;
        rd_t  r;
        g.port = p; g.we = w; g.addr = a; g.data = d;
        exp_gnt_q.push_back(g);
        if (w) begin
            ref_mem[a] = d;
        end else if (!aborted) begin
            r.port = p; r.data = ref_mem[a];
            exp_rd_q.push_back(r);
        end
    endtask

    task automatic drive_port(input logic p, input logic w, input logic [11:0] a, input logic [31:0] d);
        if (p) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
        else   begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    endtask

    // Holds each req until that port has reached its grant target, then drops it.
    task automatic hold_until(input int tgt0, input int tgt1);
        int left = 200;
        while ((gnt_cnt0 < tgt0 || gnt_cnt1 < tgt1) && left > 0) begin
            @(posedge clk); #1;
            if (gnt_cnt0 >= tgt0) req0 = 1'b0;
            if (gnt_cnt1 >= tgt1) req1 = 1'b0;
            left--;
        end
        if (left == 0) begin req0 = 1'b0; req1 = 1'b0; end
        check("gnt_count0", 64'(gnt_cnt0), 64'(tgt0));
        check("gnt_count1", 64'(gnt_cnt1), 64'(tgt1));
    endtask

    task automatic do_access(input logic p, input logic w, input logic [11:0] a, input logic [31:0] d);
        int t0, t1;
        t0 = gnt_cnt0 + (p ? 0 : 1);
        t1 = gnt_cnt1 + (p ? 1 : 0);
        expect_access(p, w, a, d, 1'b0);
        drive_port(p, w, a, d);
        hold_until(t0, t1);
    endtask

    task automatic wait_reads();
        int left = 50;
        while (exp_rd_q.size() != 0 && left > 0) begin
            @(posedge clk); #1;
            left--;
        end
        check("reads_drained", 64'(exp_rd_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, saved1;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'({gnt0, gnt1}), 64'd0);
        check("rst_rvalid", 64'({rvalid0, rvalid1}), 64'd0);
        check("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
        check("rst_dm", 64'({we_DM, addDM, dataDM}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Port-0 write: memory strobe must last exactly one cycle.
        do_access(1'b0, 1'b1, 12'h001, 32'h0000_1DFE);
        check("wr_we_DM_after", 64'(we_DM), 64'd0);
        check("wr_addDM_hold", 64'(addDM), 64'h001);
        check("wr_dataDM_hold", 64'(dataDM), 64'h1DFE);
        check("wr_busy_after", 64'(busy), 64'd0);

        // Port-1 read-back of the same word.
        do_access(1'b1, 1'b0, 12'h001, 32'h0);
        check("rd_busy_rwait", 64'(busy), 64'd1);
        wait_reads();
        check("rd_rdata0_untouched", 64'(rdata0), 64'd0);

        // Conflict: both ports write with reqs held across four accesses.
        t0 = gnt_cnt0; t1 = gnt_cnt1;
`ifdef DM_ARB_FIXED_PRIO_EN
        repeat (4) expect_access(1'b0, 1'b1, 12'h002, 32'h0000_1EFE, 1'b0);
        expect_access(1'b1, 1'b1, 12'h003, 32'h0000_1001, 1'b0);
        t0 = t0 + 4; t1 = t1 + 1;
`else
        repeat (2) begin
            expect_access(1'b0, 1'b1, 12'h002, 32'h0000_1EFE, 1'b0);
            expect_access(1'b1, 1'b1, 12'h003, 32'h0000_1001, 1'b0);
        end
        t0 = t0 + 2; t1 = t1 + 2;
`endif
        we0 = 1'b1; addr0 = 12'h002; wdata0 = 32'h0000_1EFE;
        we1 = 1'b1; addr1 = 12'h003; wdata1 = 32'h0000_1001;
        req0 = 1'b1; req1 = 1'b1;
        hold_until(t0, t1);

        // Top of the address range passes through unmodified.
        do_access(1'b1, 1'b1, 12'hFFF, 32'hA5A5_5A5A);
        do_access(1'b0, 1'b0, 12'hFFF, 32'h0);
        wait_reads();

        // Withdrawn request: req1 pulses for one cycle while port 0 is mid-read.
        expect_access(1'b0, 1'b0, 12'h001, 32'h0, 1'b0);
        drive_port(1'b0, 1'b0, 12'h001, 32'h0);
        hold_until(gnt_cnt0 + 1, gnt_cnt1);
        saved1 = gnt_cnt1;
        drive_port(1'b1, 1'b1, 12'h3FF, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        req1 = 1'b0;
        wait_reads();
        repeat (3) @(posedge clk);
        #1;
        check("withdrawn_no_gnt1", 64'(gnt_cnt1), 64'(saved1));
        do_access(1'b1, 1'b0, 12'h3FF, 32'h0);
        wait_reads();

        // Reset during RWAIT aborts the read without an rvalid.
        expect_access(1'b0, 1'b0, 12'h002, 32'h0, 1'b1);
        drive_port(1'b0, 1'b0, 12'h002, 32'h0);
        hold_until(gnt_cnt0 + 1, gnt_cnt1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we_DM", 64'(we_DM), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rdata0", 64'(rdata0), 64'd0);
        check("abort_dm_bus", 64'({addDM, dataDM}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_rvalid", 64'({rvalid0, rvalid1}), 64'd0);

        // Pointer is back at port 1, so port 0 wins the first conflict after reset.
        t0 = gnt_cnt0 + 1; t1 = gnt_cnt1 + 1;
        expect_access(1'b0, 1'b0, 12'h002, 32'h0, 1'b0);
        expect_access(1'b1, 1'b0, 12'h003, 32'h0, 1'b0);
        rst_n = 1'b1;
        drive_port(1'b0, 1'b0, 12'h002, 32'h0);
        drive_port(1'b1, 1'b0, 12'h003, 32'h0);
        @(posedge clk); #1;
        check("first_req_after_reset", 64'({gnt0, gnt1}), 64'b10);
        hold_until(t0, t1);
        wait_reads();

        check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
